// File: rtl/cache_line_fill_pkg.sv
// Shared types and constants for the cache line refill engine.
package cache_line_fill_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned INDEX_W    = 4;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned OFFSET_W   = 4;
    localparam int unsigned WOFF_W     = 2;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;

    typedef enum logic [2:0] {
        FILL_IDLE  = 3'd0,
        FILL_AREQ  = 3'd1,
        FILL_RECV  = 3'd2,
        FILL_WRITE = 3'd3,
        FILL_DONE  = 3'd4
    } fill_state_e;

    // Captured miss address without the byte-in-word bits.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [WOFF_W-1:0]  word;
    } fill_addr_t;

endpackage

// File: rtl/cache_line_fill_line_buffer.sv
// fill_line_buffer: 4x32 beat buffer with a 2-bit write pointer.
//   clk, rst     : clock, async active-high reset (clears words and count)
//   clr_i        : restart a fill (clears words and count)
//   wen_i        : store wdata_i at word[cnt] and advance cnt
//   wdata_i      : beat data
//   line_o       : {word3, word2, word1, word0}
//   cnt_o        : number of beats stored so far (mod 4)
module fill_line_buffer
    import cache_line_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wen_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [LINE_W-1:0] line_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [WORD_W-1:0] word_q [LINE_WORDS];
    logic [CNT_W-1:0]  cnt_q;

    // Beat storage; clear takes priority over a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) word_q[i] <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < LINE_WORDS; i++) word_q[i] <= '0;
            cnt_q <= '0;
        end else if (wen_i) begin
            word_q[cnt_q] <= wdata_i;
            cnt_q         <= cnt_q + CNT_W'(1);
        end
    end

    assign line_o = {word_q[3], word_q[2], word_q[1], word_q[0]};
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/cache_line_fill.sv
// cache_line_fill: miss refill engine in front of the cache data array.
// Fetches a 4-word line with one read burst, forwards the critical word,
// then writes the whole line and its tag in a single cycle.
//   miss_req/miss_addr/miss_ready : CPU-side miss handshake
//   mem_ar*                      : burst read address channel (len fixed at 3)
//   mem_r*                       : read data channel
//   line_* / tag_*               : data and tag array write port
//   crit_valid/crit_data         : registered critical word pulse
//   fill_done/fill_err           : completion pulse and burst-length error
module cache_line_fill
    import cache_line_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [ADDR_W-1:0]     miss_addr,
    output logic                  miss_ready,
    output logic                  mem_arvalid,
    output logic [ADDR_W-1:0]     mem_araddr,
    output logic [1:0]            mem_arlen,
    input  logic                  mem_arready,
    input  logic                  mem_rvalid,
    input  logic [WORD_W-1:0]     mem_rdata,
    input  logic                  mem_rlast,
    output logic                  mem_rready,
    output logic                  line_wen,
    output logic [INDEX_W-1:0]    line_index,
    output logic [LINE_W-1:0]     line_data,
    output logic [LINE_BYTES-1:0] line_strb,
    output logic                  tag_wen,
    output logic [TAG_W-1:0]      tag_out,
    output logic                  crit_valid,
    output logic [WORD_W-1:0]     crit_data,
    output logic                  fill_done,
    output logic                  fill_err
);

    fill_state_e state_q, state_d;
    fill_addr_t  addr_q, addr_d;
    logic        err_q, err_d;
    logic        capture_c;
    logic        beat_c;
    logic [CNT_W-1:0] cnt;

    logic                  miss_ready_q, miss_ready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  line_wen_q, line_wen_d;
    logic [LINE_BYTES-1:0] strb_q, strb_d;
    logic                  tag_wen_q, tag_wen_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [WORD_W-1:0]     crit_data_q, crit_data_d;
    logic                  fill_done_q, fill_done_d;
    logic                  fill_err_q, fill_err_d;

    // Byte-in-word bits never affect a line fill.
    logic unused_byte_bits;
    assign unused_byte_bits = &{1'b0, miss_addr[1:0]};

    fill_line_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (capture_c),
        .wen_i   (beat_c),
        .wdata_i (mem_rdata),
        .line_o  (line_data),
        .cnt_o   (cnt)
    );

    // State register plus the datapath registers that follow it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL_IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; a beat is accepted whenever rvalid is seen in RECV.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        err_d     = err_q;
        capture_c = 1'b0;
        beat_c    = 1'b0;
        unique case (state_q)
            FILL_IDLE: begin
                if (miss_req) begin
                    capture_c = 1'b1;
                    addr_d    = fill_addr_t'(miss_addr[ADDR_W-1:2]);
                    err_d     = 1'b0;
                    state_d   = FILL_AREQ;
                end
            end
            FILL_AREQ: begin
                if (mem_arready) state_d = FILL_RECV;
            end
            FILL_RECV: begin
                if (mem_rvalid) begin
                    beat_c = 1'b1;
                    if (mem_rlast) begin
                        if (cnt == CNT_W'(LINE_WORDS - 1)) begin
                            state_d = FILL_WRITE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = FILL_DONE;
                        end
                    end else if (cnt == CNT_W'(LINE_WORDS - 1)) begin
                        // Fourth beat without rlast: keep it but flag the burst.
                        err_d   = 1'b1;
                        state_d = FILL_DONE;
                    end
                end
            end
            FILL_WRITE: state_d = FILL_DONE;
            FILL_DONE:  state_d = FILL_IDLE;
            default:    state_d = FILL_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        miss_ready_d = (state_d == FILL_IDLE);
        arvalid_d    = (state_d == FILL_AREQ);
        rready_d     = (state_d == FILL_RECV);
        line_wen_d   = (state_d == FILL_WRITE);
        tag_wen_d    = (state_d == FILL_WRITE);
        strb_d       = (state_d == FILL_WRITE) ? {LINE_BYTES{1'b1}} : '0;
        fill_done_d  = (state_d == FILL_DONE);
        fill_err_d   = (state_d == FILL_DONE) && err_d;
        crit_valid_d = beat_c && (cnt == addr_q.word);
        crit_data_d  = crit_valid_d ? mem_rdata : crit_data_q;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_ready_q <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            line_wen_q   <= 1'b0;
            tag_wen_q    <= 1'b0;
            strb_q       <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            fill_done_q  <= 1'b0;
            fill_err_q   <= 1'b0;
        end else begin
            miss_ready_q <= miss_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            line_wen_q   <= line_wen_d;
            tag_wen_q    <= tag_wen_d;
            strb_q       <= strb_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            fill_done_q  <= fill_done_d;
            fill_err_q   <= fill_err_d;
        end
    end

    assign miss_ready  = miss_ready_q;
    assign mem_arvalid = arvalid_q;
    assign mem_araddr  = {addr_q.tag, addr_q.index, OFFSET_W'(0)};
    assign mem_arlen   = 2'(LINE_WORDS - 1);
    assign mem_rready  = rready_q;
    assign line_wen    = line_wen_q;
    assign line_index  = addr_q.index;
    assign line_strb   = strb_q;
    assign tag_wen     = tag_wen_q;
    assign tag_out     = addr_q.tag;
    assign crit_valid  = crit_valid_q;
    assign crit_data   = crit_data_q;
    assign fill_done   = fill_done_q;
    assign fill_err    = fill_err_q;

endmodule
